wb_statis: RTL and testbench

White-balance statistics stage in the raw data channel, directly downstream of the white-balance gain stage. It consumes that stage's fval/lval/pixel stream, classifies each Bayer pixel as R, G or B, and accumulates per-colour sums inside a programmable window. At frame end it latches the results for firmware, which uses them to compute the next frame's R/G/B gain coefficients.

---
 rtl/wb_statis_pkg.sv | 60 ++++++
 rtl/wb_bayer_pos.sv | 80 ++++++++
 rtl/wb_statis.sv | 180 ++++++++++++++++++
 tb/tb_wb_statis.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/wb_statis_pkg.sv
// ---------------------------------------------------------------------------
// wb_statis_pkg : Bayer pattern, colour and state encodings.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wb_statis_pkg;

   localparam logic [1:0] PAT_GR = 2'b00;
   localparam logic [1:0] PAT_RG = 2'b01;
   localparam logic [1:0] PAT_GB = 2'b10;
   localparam logic [1:0] PAT_BG = 2'b11;

   typedef enum logic [1:0] {
      COL_R = 2'd0,
      COL_G = 2'd1,
      COL_B = 2'd2
   } color_t;

   typedef enum logic [2:0] {
      ST_WAIT_IDLE  = 3'd0,
      ST_WAIT_FRAME = 3'd1,
      ST_ACCUM      = 3'd2,
      ST_DRAIN      = 3'd3,
      ST_LATCH      = 3'd4
   } state_t;

   // Colour of the pixel at parity position {y[0], x[0]} for a given pattern.
   function automatic color_t bayer_color(input logic [1:0] pat,
                                          input logic       y0,
                                          input logic       x0);
      color_t c;
      c = COL_G;
      case (pat)
         PAT_GR: case ({y0, x0})
                    2'b01:   c = COL_R;
                    2'b10:   c = COL_B;
                    default: c = COL_G;
                 endcase
         PAT_RG: case ({y0, x0})
                    2'b00:   c = COL_R;
                    2'b11:   c = COL_B;
                    default: c = COL_G;
                 endcase
         PAT_GB: case ({y0, x0})
                    2'b01:   c = COL_B;
                    2'b10:   c = COL_R;
                    default: c = COL_G;
                 endcase
         default: case ({y0, x0})
                    2'b00:   c = COL_B;
                    2'b11:   c = COL_R;
                    default: c = COL_G;
                 endcase
      endcase
      return c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/wb_bayer_pos.sv
// ---------------------------------------------------------------------------
// wb_bayer_pos : x/y position counters, window test and colour decode.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_bayer_pos
   import wb_statis_pkg::*;
#(
   parameter int SENSOR_DAT_WIDTH = 10,
   parameter int WIN_WD           = 13
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        i_fval,
   input  logic                        i_lval,
   input  logic [SENSOR_DAT_WIDTH-1:0] iv_pix_data,
   input  logic [1:0]                  iv_pattern,
   input  logic [WIN_WD-1:0]           iv_off_x,
   input  logic [WIN_WD-1:0]           iv_off_y,
   input  logic [WIN_WD-1:0]           iv_width,
   input  logic [WIN_WD-1:0]           iv_height,
   output logic                        o_in_win,
   output logic [SENSOR_DAT_WIDTH-1:0] ov_pix,
   output color_t                      o_color
);

   localparam int             CW    = WIN_WD + 1;
   localparam logic [CW-1:0]  c_one = CW'(1);

   logic [CW-1:0]             r_x;
   logic [CW-1:0]             r_y;
   logic                      r_lval_d;
   logic                      r_in_win;
   logic [SENSOR_DAT_WIDTH-1:0] r_pix;
   color_t                    r_color;

   logic [CW-1:0]             w_x_end;
   logic [CW-1:0]             w_y_end;
   logic                      w_in_x;
   logic                      w_in_y;

   // Window ends carry one extra bit so offset+size can never overflow.
   assign w_x_end = {1'b0, iv_off_x} + {1'b0, iv_width};
   assign w_y_end = {1'b0, iv_off_y} + {1'b0, iv_height};
   assign w_in_x  = (r_x >= {1'b0, iv_off_x}) && (r_x < w_x_end);
   assign w_in_y  = (r_y >= {1'b0, iv_off_y}) && (r_y < w_y_end);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_x      <= '0;
         r_y      <= '0;
         r_lval_d <= 1'b0;
         r_in_win <= 1'b0;
         r_pix    <= '0;
         r_color  <= COL_G;
      end else begin
         r_lval_d <= i_lval;
         if (i_lval) begin
            if (!(&r_x))
               r_x <= r_x + c_one;
         end else begin
            r_x <= '0;
         end
         if (!i_fval)
            r_y <= '0;
         else if (r_lval_d && !i_lval && !(&r_y))
            r_y <= r_y + c_one;
         r_in_win <= i_lval && w_in_x && w_in_y;
         r_pix    <= iv_pix_data;
         r_color  <= bayer_color(iv_pattern, r_y[0], r_x[0]);
      end
   end

   assign o_in_win = r_in_win;
   assign ov_pix   = r_pix;
   assign o_color  = r_color;

endmodule

`default_nettype wire

// File: rtl/wb_statis.sv
// ---------------------------------------------------------------------------
// wb_statis : windowed per-colour white-balance statistics.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_statis
   import wb_statis_pkg::*;
#(
   parameter int SENSOR_DAT_WIDTH = 10,
   parameter int WIN_WD           = 13,
   parameter int SUM_WD           = 32
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        i_fval,
   input  logic                        i_lval,
   input  logic [SENSOR_DAT_WIDTH-1:0] iv_pix_data,
   input  logic [1:0]                  iv_bayer_pattern,
   input  logic [WIN_WD-1:0]           iv_win_offset_x,
   input  logic [WIN_WD-1:0]           iv_win_offset_y,
   input  logic [WIN_WD-1:0]           iv_win_width,
   input  logic [WIN_WD-1:0]           iv_win_height,
   output logic [SUM_WD-1:0]           ov_wb_statis_r,
   output logic [SUM_WD-1:0]           ov_wb_statis_g,
   output logic [SUM_WD-1:0]           ov_wb_statis_b,
   output logic [SUM_WD-1:0]           ov_wb_pix_num,
   output logic                        o_wb_statis_done
);

   localparam int                PAD   = SUM_WD - SENSOR_DAT_WIDTH;
   localparam logic [SUM_WD-1:0] c_one = SUM_WD'(1);

   logic [1:0]                  r_pattern;
   logic [WIN_WD-1:0]           r_off_x;
   logic [WIN_WD-1:0]           r_off_y;
   logic [WIN_WD-1:0]           r_width;
   logic [WIN_WD-1:0]           r_height;

   state_t                      r_state;
   logic                        r_fval_d;
   logic                        r_drain_cnt;
   logic [SUM_WD-1:0]           r_acc_r;
   logic [SUM_WD-1:0]           r_acc_g;
   logic [SUM_WD-1:0]           r_acc_b;
   logic [SUM_WD-1:0]           r_acc_n;
   logic [SUM_WD-1:0]           r_out_r;
   logic [SUM_WD-1:0]           r_out_g;
   logic [SUM_WD-1:0]           r_out_b;
   logic [SUM_WD-1:0]           r_out_n;
   logic                        r_done;

   logic                        w_in_win;
   logic [SENSOR_DAT_WIDTH-1:0] w_pix;
   color_t                      w_color;
   logic [SUM_WD-1:0]           w_pix_ext;
   logic                        w_acc_en;

   function automatic logic [SUM_WD-1:0] sat_add(input logic [SUM_WD-1:0] a,
                                                 input logic [SUM_WD-1:0] b);
      logic [SUM_WD:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[SUM_WD] ? {SUM_WD{1'b1}} : s[SUM_WD-1:0];
   endfunction

   // Configuration is only allowed to move during vertical blanking.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_pattern <= PAT_GR;
         r_off_x   <= '0;
         r_off_y   <= '0;
         r_width   <= '0;
         r_height  <= '0;
      end else if (!i_fval) begin
         r_pattern <= iv_bayer_pattern;
         r_off_x   <= iv_win_offset_x;
         r_off_y   <= iv_win_offset_y;
         r_width   <= iv_win_width;
         r_height  <= iv_win_height;
      end
   end

   wb_bayer_pos #(
      .SENSOR_DAT_WIDTH (SENSOR_DAT_WIDTH),
      .WIN_WD           (WIN_WD)
   ) u_pos (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_fval      (i_fval),
      .i_lval      (i_lval),
      .iv_pix_data (iv_pix_data),
      .iv_pattern  (r_pattern),
      .iv_off_x    (r_off_x),
      .iv_off_y    (r_off_y),
      .iv_width    (r_width),
      .iv_height   (r_height),
      .o_in_win    (w_in_win),
      .ov_pix      (w_pix),
      .o_color     (w_color)
   );

   assign w_pix_ext = {{PAD{1'b0}}, w_pix};
   assign w_acc_en  = w_in_win && ((r_state == ST_ACCUM) || (r_state == ST_DRAIN));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= ST_WAIT_IDLE;
         r_fval_d    <= 1'b0;
         r_drain_cnt <= 1'b0;
         r_acc_r     <= '0;
         r_acc_g     <= '0;
         r_acc_b     <= '0;
         r_acc_n     <= '0;
         r_out_r     <= '0;
         r_out_g     <= '0;
         r_out_b     <= '0;
         r_out_n     <= '0;
         r_done      <= 1'b0;
      end else begin
         r_fval_d <= i_fval;
         r_done   <= 1'b0;
         case (r_state)
            ST_WAIT_IDLE: begin
               if (!i_fval)
                  r_state <= ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
               r_acc_r     <= '0;
               r_acc_g     <= '0;
               r_acc_b     <= '0;
               r_acc_n     <= '0;
               r_drain_cnt <= 1'b0;
               if (i_fval && !r_fval_d)
                  r_state <= ST_ACCUM;
            end
            ST_ACCUM: begin
               if (!i_fval && r_fval_d)
                  r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               // Results are loaded on the edge into LATCH so they appear
               // together with the done pulse.
               if (r_drain_cnt) begin
                  r_state <= ST_LATCH;
                  r_out_r <= r_acc_r;
                  r_out_g <= r_acc_g;
                  r_out_b <= r_acc_b;
                  r_out_n <= r_acc_n;
                  r_done  <= 1'b1;
               end else begin
                  r_drain_cnt <= 1'b1;
               end
            end
            ST_LATCH: begin
               r_state <= ST_WAIT_FRAME;
            end
            default: begin
               r_state <= ST_WAIT_IDLE;
            end
         endcase

         if (w_acc_en) begin
            r_acc_n <= sat_add(r_acc_n, c_one);
            case (w_color)
               COL_R:   r_acc_r <= sat_add(r_acc_r, w_pix_ext);
               COL_B:   r_acc_b <= sat_add(r_acc_b, w_pix_ext);
               default: r_acc_g <= sat_add(r_acc_g, w_pix_ext);
            endcase
         end
      end
   end

   assign ov_wb_statis_r   = r_out_r;
   assign ov_wb_statis_g   = r_out_g;
   assign ov_wb_statis_b   = r_out_b;
   assign ov_wb_pix_num    = r_out_n;
   assign o_wb_statis_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_wb_statis.sv
// ---------------------------------------------------------------------------
// tb_wb_statis : directed bench for wb_statis.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wb_statis;

   logic        clk;
   logic        reset_n;
   logic        fval;
   logic        lval;
   logic [9:0]  pix;
   logic [1:0]  pattern;
   logic [12:0] ox, oy, ww, wh;

   logic [31:0] r, g, b, pn;
   logic        done;
   logic [11:0] sr, sg, sb, sp;
   logic        sdone;

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wb_statis u_dut (
      .clk (clk), .reset_n (reset_n), .i_fval (fval), .i_lval (lval),
      .iv_pix_data (pix), .iv_bayer_pattern (pattern),
      .iv_win_offset_x (ox), .iv_win_offset_y (oy),
      .iv_win_width (ww), .iv_win_height (wh),
      .ov_wb_statis_r (r), .ov_wb_statis_g (g), .ov_wb_statis_b (b),
      .ov_wb_pix_num (pn), .o_wb_statis_done (done)
   );

   wb_statis #(.SUM_WD(12)) u_sat (
      .clk (clk), .reset_n (reset_n), .i_fval (fval), .i_lval (lval),
      .iv_pix_data (pix), .iv_bayer_pattern (pattern),
      .iv_win_offset_x (ox), .iv_win_offset_y (oy),
      .iv_win_width (ww), .iv_win_height (wh),
      .ov_wb_statis_r (sr), .ov_wb_statis_g (sg), .ov_wb_statis_b (sb),
      .ov_wb_pix_num (sp), .o_wb_statis_done (sdone)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // 0=R 1=G 2=B, indexed by pattern and {y0,x0}
   function automatic int tb_color(input logic [1:0] pat, input int x, input int y);
      int pos;
      pos = ((y % 2) * 2) + (x % 2);
      case (pat)
         2'b00: case (pos) 1: return 0; 2: return 2; default: return 1; endcase
         2'b01: case (pos) 0: return 0; 3: return 2; default: return 1; endcase
         2'b10: case (pos) 1: return 2; 2: return 0; default: return 1; endcase
         default: case (pos) 0: return 2; 3: return 0; default: return 1; endcase
      endcase
   endfunction

   function automatic logic [9:0] pval(input int mode, input int cval, input int x, input int y);
      int c;
      if (mode == 0) return 10'(cval);
      if (mode == 1) return 10'(x);
      c = tb_color(pattern, x, y);
      return (c == 0) ? 10'd10 : (c == 1) ? 10'd20 : 10'd30;
   endfunction

   // ev_kind: 1 = one-cycle reset after line ev_line, 2 = config change there
   task automatic send_frame(input int w, input int h, input int mode, input int cval,
                             input int ev_line, input int ev_kind);
      fval = 1'b1;
      tick();
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            lval = 1'b1;
            pix  = pval(mode, cval, x, y);
            tick();
         end
         lval = 1'b0;
         pix  = '0;
         if (y == ev_line && ev_kind == 1) begin
            reset_n = 1'b0;
            tick();
            chk("rst_r", r, 0);
            chk("rst_g", g, 0);
            chk("rst_b", b, 0);
            chk("rst_pix", pn, 0);
            chk("rst_done", done, 0);
            reset_n = 1'b1;
         end
         if (y == ev_line && ev_kind == 2) begin
            ww      = 13'd0;
            pattern = 2'b11;
         end
         repeat (3) tick();
      end
      fval = 1'b0;
   endtask

   // Cycles from the first fval=0 cycle to the done pulse; 99 if none in 10.
   task automatic wait_done(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!done && n < 10);
      if (!done) n = 99;
   endtask

   task automatic chk_res(input string tag, input int er, input int eg,
                          input int eb, input int en);
      int n;
      wait_done(n);
      chk({tag, "_done_lat"}, n, 3);
      chk({tag, "_r"}, r, er);
      chk({tag, "_g"}, g, eg);
      chk({tag, "_b"}, b, eb);
      chk({tag, "_pix"}, pn, en);
      tick();
      chk({tag, "_done_low"}, done, 0);
      repeat (4) tick();
   endtask

   initial begin
      int n;
      reset_n = 1'b0; fval = 1'b0; lval = 1'b0; pix = '0;
      pattern = 2'b00; ox = '0; oy = '0; ww = 13'd8; wh = 13'd4;
      repeat (3) tick();
      chk("reset_r", r, 0);
      chk("reset_g", g, 0);
      chk("reset_b", b, 0);
      chk("reset_pix", pn, 0);
      chk("reset_done", done, 0);
      reset_n = 1'b1;
      repeat (3) tick();

      // Full 8x4 GR frame, constant 100
      send_frame(8, 4, 0, 100, -1, 0);
      chk_res("full", 800, 1600, 800, 32);

      // Window (2,1) 4x2 over an x ramp
      ox = 13'd2; oy = 13'd1; ww = 13'd4; wh = 13'd2;
      repeat (2) tick();
      send_frame(8, 4, 1, 0, -1, 0);
      chk_res("ramp", 8, 14, 6, 8);

      // Pattern sweep on a 4x4 frame: R=10, G=20, B=30
      ox = '0; oy = '0; ww = 13'd4; wh = 13'd4;
      pattern = 2'b01; repeat (2) tick();
      send_frame(4, 4, 2, 0, -1, 0);
      chk_res("pat_rg", 40, 160, 120, 16);
      pattern = 2'b10; repeat (2) tick();
      send_frame(4, 4, 2, 0, -1, 0);
      chk_res("pat_gb", 40, 160, 120, 16);
      pattern = 2'b11; repeat (2) tick();
      send_frame(4, 4, 2, 0, -1, 0);
      chk_res("pat_bg", 40, 160, 120, 16);

      // 16x16 frame of 1023: 64 R, 128 G, 64 B pixels
      pattern = 2'b00; ww = 13'd16; wh = 13'd16; repeat (2) tick();
      send_frame(16, 16, 0, 1023, -1, 0);
      chk_res("big", 65472, 130944, 65472, 256);
      chk("sat_r", sr, 4095);
      chk("sat_g", sg, 4095);
      chk("sat_b", sb, 4095);
      chk("sat_pix", sp, 256);

      // Reset in the middle of a frame discards it
      ww = 13'd8; wh = 13'd4; repeat (2) tick();
      send_frame(8, 4, 0, 100, 1, 1);
      wait_done(n);
      chk("rst_no_done", n, 99);
      send_frame(8, 4, 0, 100, -1, 0);
      chk_res("after_rst", 800, 1600, 800, 32);

      // Width/pattern change mid-frame only applies to the next frame
      send_frame(8, 4, 0, 100, 1, 2);
      chk_res("cfg_frozen", 800, 1600, 800, 32);
      send_frame(8, 4, 0, 100, -1, 0);
      chk_res("width0", 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
